// File: rtl/capture_pkg.sv
// Shared types and default sizing for the logic-analyzer capture sequencer.
package capture_pkg;

    localparam int FIFO_DEPTH = 32768;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } cap_state_e;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'b00,
        RISING    = 2'b01,
        FALLING   = 2'b10,
        LEVEL     = 2'b11
    } trig_mode_e;

endpackage

// File: rtl/capture_trig_detect.sv
// Trigger detector: registers trig_in every cycle and flags a mode-dependent
// condition that only counts on a cycle carrying a valid sample.
module capture_trig_detect
    import capture_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  trig_mode_e mode,
    input  logic       trig_in,
    input  logic       sample_valid,
    output logic       trig_hit
);

    logic trig_q_reg;
    logic cond;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q_reg <= 1'b0;
        end else begin
            trig_q_reg <= trig_in;
        end
    end

    always_comb begin
        cond = 1'b0;
        case (mode)
            IMMEDIATE: cond = 1'b1;
            RISING:    cond = trig_in & ~trig_q_reg;
            FALLING:   cond = ~trig_in & trig_q_reg;
            LEVEL:     cond = trig_in;
            default:   cond = 1'b0;
        endcase
    end

    assign trig_hit = cond & sample_valid;

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture sequencer for sample_fifo: clear, arm trigger, write N qualified samples,
// then drain to a valid/ready consumer. At most one FIFO operation per cycle.
module sample_capture_ctrl #(
    parameter int DATA_W     = capture_pkg::DATA_W,
    parameter int FIFO_DEPTH = capture_pkg::FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  sample_count,
    input  logic [1:0]        trig_mode,
    input  logic              trig_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              fifo_en,
    output logic              fifo_rnw,
    output logic              fifo_clear,
    output logic [DATA_W-1:0] fifo_data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out
);
    import capture_pkg::*;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    cap_state_e       state_reg, state_next;
    trig_mode_e       mode_reg, mode_next;
    logic [CNT_W-1:0] target_reg, target_next;
    logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0] rd_cnt_reg, rd_cnt_next;
    logic             overflow_reg, overflow_next;

    logic             trig_hit;
    logic             wr_req, rd_req, clr_req;
    logic             drain_avail;
    logic [CNT_W-1:0] start_target;

    capture_trig_detect u_trig_detect (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode_reg),
        .trig_in      (trig_in),
        .sample_valid (sample_valid),
        .trig_hit     (trig_hit)
    );

    // A zero or oversized request means "fill the whole buffer".
    assign start_target = ((sample_count == '0) || (sample_count > DEPTH_CNT)) ?
                          DEPTH_CNT : sample_count;

    assign drain_avail = !fifo_empty && (rd_cnt_reg != wr_cnt_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= IMMEDIATE;
            target_reg   <= '0;
            wr_cnt_reg   <= '0;
            rd_cnt_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            target_reg   <= target_next;
            wr_cnt_reg   <= wr_cnt_next;
            rd_cnt_reg   <= rd_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        target_next   = target_reg;
        wr_cnt_next   = wr_cnt_reg;
        rd_cnt_next   = rd_cnt_reg;
        overflow_next = overflow_reg;
        wr_req        = 1'b0;
        rd_req        = 1'b0;
        clr_req       = 1'b0;
        out_valid     = 1'b0;
        done          = 1'b0;

        // Abort overrides everything, including a simultaneous start or FIFO op.
        if (abort) begin
            clr_req    = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        target_next   = start_target;
                        mode_next     = trig_mode_e'(trig_mode);
                        wr_cnt_next   = '0;
                        rd_cnt_next   = '0;
                        overflow_next = 1'b0;
                        state_next    = ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    clr_req    = 1'b1;
                    state_next = (mode_reg == IMMEDIATE) ? ST_CAPTURE : ST_WAIT_TRIG;
                end

                ST_WAIT_TRIG: begin
                    // The triggering sample itself is sample 1.
                    if (trig_hit) begin
                        if (fifo_full) begin
                            overflow_next = 1'b1;
                            state_next    = ST_DRAIN;
                        end else begin
                            wr_req      = 1'b1;
                            wr_cnt_next = ONE_CNT;
                            state_next  = (target_reg == ONE_CNT) ? ST_DRAIN : ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (sample_valid) begin
                        if (fifo_full) begin
                            overflow_next = 1'b1;
                            state_next    = ST_DRAIN;
                        end else begin
                            wr_req      = 1'b1;
                            wr_cnt_next = wr_cnt_reg + ONE_CNT;
                            if (wr_cnt_next == target_reg) begin
                                state_next = ST_DRAIN;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (rd_cnt_reg == wr_cnt_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        out_valid = drain_avail;
                        if (drain_avail && out_ready) begin
                            rd_req      = 1'b1;
                            rd_cnt_next = rd_cnt_reg + ONE_CNT;
                            if (rd_cnt_next == wr_cnt_reg) begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign fifo_en      = wr_req | rd_req;
    assign fifo_rnw     = rd_req;
    assign fifo_clear   = clr_req;
    assign fifo_data_in = wr_req ? sample_in : '0;

    assign out_data = out_valid ? fifo_data_out : '0;
    assign busy     = (state_reg != ST_IDLE);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Bench for sample_capture_ctrl: behavioural FIFO + session-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_sample_capture_ctrl;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 32768;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  sample_count = '0;
    logic [1:0]        trig_mode = '0;
    logic              trig_in = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy, done, overflow;
    logic              fifo_en, fifo_rnw, fifo_clear;
    logic [DATA_W-1:0] fifo_data_in;
    logic              fifo_full = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data_out = '0;

    always #5 clk = ~clk;

    sample_capture_ctrl #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .sample_count  (sample_count),
        .trig_mode     (trig_mode),
        .trig_in       (trig_in),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .fifo_en       (fifo_en),
        .fifo_rnw      (fifo_rnw),
        .fifo_clear    (fifo_clear),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // First-word-fall-through FIFO with registered flags; capacity adjustable.
    logic [7:0] fq[$];
    int fifo_cap = FIFO_DEPTH;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) fq.delete();
        else if (fifo_clear) fq.delete();
        else if (fifo_en && !fifo_rnw) begin
            if (fq.size() < fifo_cap) fq.push_back(fifo_data_in);
        end else if (fifo_en && fifo_rnw) begin
            if (fq.size() > 0) void'(fq.pop_front());
        end
        fifo_empty    <= (fq.size() == 0);
        fifo_full     <= (fq.size() >= fifo_cap);
        fifo_data_out <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    // Session-level reference model.
    bit m_busy = 0, m_clear_due = 0, m_armed = 0, m_capturing = 0;
    bit m_draining = 0, m_done_due = 0, m_ovf = 0, m_trig_prev = 0;
    int m_wr = 0, m_rd = 0, m_target = 0;
    logic [1:0] m_mode = '0;
    logic [7:0] exp_q[$];

    // Observations of the DUT, reset per scenario.
    int n_wr = 0, n_pop = 0, n_pop_nordy = 0, n_pop_empty = 0, n_done = 0, n_clr = 0;
    logic [7:0] popped[$];

    function automatic bit trig_cond(input logic [1:0] mode, input logic t, input logic p);
        case (mode)
            2'd1:    return t & ~p;
            2'd2:    return ~t & p;
            2'd3:    return t;
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin : model_blk
        logic        e_busy, e_done, e_ovf, e_ov, e_wr, e_rd, e_clr;
        logic [7:0]  e_data, e_din;
        logic [22:0] exp_v, act_v;
        if (!reset_n) begin
            m_busy = 0; m_clear_due = 0; m_armed = 0; m_capturing = 0;
            m_draining = 0; m_done_due = 0; m_ovf = 0; m_trig_prev = 0;
            m_wr = 0; m_rd = 0; m_target = 0; exp_q.delete();
        end else begin
            e_busy = m_busy; e_ovf = m_ovf;
            e_done = 0; e_ov = 0; e_wr = 0; e_rd = 0; e_clr = 0;
            e_data = 8'h00; e_din = 8'h00;
            if (abort) begin
                e_clr = 1;
                m_busy = 0; m_clear_due = 0; m_armed = 0; m_capturing = 0;
                m_draining = 0; m_done_due = 0;
                exp_q.delete();
            end else if (!m_busy) begin
                if (start) begin
                    m_target = (sample_count == 0 || sample_count > FIFO_DEPTH) ?
                               FIFO_DEPTH : int'(sample_count);
                    m_mode = trig_mode; m_wr = 0; m_rd = 0; m_ovf = 0;
                    m_busy = 1; m_clear_due = 1;
                    exp_q.delete();
                end
            end else if (m_clear_due) begin
                e_clr = 1; m_clear_due = 0;
                if (m_mode == 2'd0) m_capturing = 1; else m_armed = 1;
            end else if (m_armed || m_capturing) begin
                bit take;
                take = m_armed ? (sample_valid && trig_cond(m_mode, trig_in, m_trig_prev))
                               : sample_valid;
                if (take) begin
                    m_armed = 0;
                    if (fifo_full) begin
                        m_ovf = 1; m_capturing = 0; m_draining = 1;
                    end else begin
                        e_wr = 1; e_din = sample_in;
                        exp_q.push_back(sample_in); m_wr++;
                        if (m_wr == m_target) begin
                            m_capturing = 0; m_draining = 1;
                        end else begin
                            m_capturing = 1;
                        end
                    end
                end
            end else if (m_draining) begin
                if (m_rd == m_wr) begin
                    m_draining = 0; m_done_due = 1;
                end else if (!fifo_empty) begin
                    e_ov = 1;
                    e_data = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
                    if (out_ready) begin
                        e_rd = 1; m_rd++;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        if (m_rd == m_wr) begin
                            m_draining = 0; m_done_due = 1;
                        end
                    end
                end
            end else if (m_done_due) begin
                e_done = 1; m_done_due = 0; m_busy = 0;
            end
            m_trig_prev = trig_in;

            exp_v = {e_busy, e_done, e_ovf, e_ov, e_data, e_wr | e_rd, e_rd, e_clr, e_din};
            act_v = {busy, done, overflow, out_valid, out_data, fifo_en, fifo_rnw, fifo_clear,
                     fifo_data_in};
            check($sformatf("cycle_outputs@%0t {busy,done,ovf,ov,data,en,rnw,clr,din}", $time),
                  64'(act_v), 64'(exp_v));

            if (fifo_en && !fifo_rnw) n_wr++;
            if (fifo_en && fifo_rnw) begin
                n_pop++;
                if (!out_ready) n_pop_nordy++;
                if (fifo_empty) n_pop_empty++;
            end
            if (out_valid && out_ready) popped.push_back(out_data);
            if (done) n_done++;
            if (fifo_clear) n_clr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_obs();
        n_wr = 0; n_pop = 0; n_pop_nordy = 0; n_pop_empty = 0; n_done = 0; n_clr = 0;
        popped.delete();
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [CNT_W-1:0] cnt);
        trig_mode = mode; sample_count = cnt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic t, input logic v, input logic [7:0] d);
        trig_in = t; sample_valid = v; sample_in = d;
        step();
    endtask

    task automatic wait_idle(input string name, input int budget, input bit rand_ready);
        for (int k = 0; k < budget && busy; k++) begin
            if (rand_ready) out_ready = 1'($urandom % 2);
            step();
        end
        check({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    function automatic logic [7:0] pop_at(input int i);
        return (popped.size() > i) ? popped[i] : 8'hxx;
    endfunction

    task automatic report(input string name);
        $display("%s: writes %0d pops %0d done %0d clears %0d overflow %0b",
                 name, n_wr, n_pop, n_done, n_clr, overflow);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset_outputs_zero",
              64'({busy, done, overflow, out_valid, out_data, fifo_en, fifo_rnw, fifo_clear,
                   fifo_data_in}), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        // Immediate mode: nothing written on the start or CLEAR cycle.
        reset_obs(); out_ready = 1'b1;
        sample_valid = 1'b1; sample_in = 8'hEE;
        start_run(2'd0, 16'd4);
        step();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'h11 * (i + 1)));
        sample_valid = 1'b0;
        wait_idle("imm", 50, 0);
        report("immediate");
        check("imm_writes", 64'(n_wr), 64'(4));
        check("imm_pops", 64'(n_pop), 64'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("imm_byte%0d", i), 64'(pop_at(i)), 64'(8'h11 * (i + 1)));
        check("imm_done", 64'(n_done), 64'(1));
        check("imm_overflow", 64'(overflow), 64'(0));

        // Rising edge, trigger input already high before start.
        reset_obs();
        drive(1'b1, 1'b0, 8'h00); drive(1'b1, 1'b0, 8'h00);
        start_run(2'd1, 16'd3);
        drive(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h5A);
        check("rise_no_early_write", 64'(n_wr), 64'(0));
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b1, 1'b1, 8'hB6);
        drive(1'b0, 1'b1, 8'hC7);
        sample_valid = 1'b0;
        wait_idle("rise", 50, 0);
        report("rising");
        check("rise_first_byte", 64'(pop_at(0)), 64'(8'hA5));
        check("rise_third_byte", 64'(pop_at(2)), 64'(8'hC7));
        check("rise_writes", 64'(n_wr), 64'(3));

        // Overflow: only two free slots against a full-size target.
        reset_obs(); fifo_cap = 2; trig_in = 1'b0; sample_valid = 1'b0;
        start_run(2'd0, 16'd0);
        step();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(8'h30 + i));
        sample_valid = 1'b0;
        wait_idle("ovf", 50, 0);
        report("overflow");
        fifo_cap = FIFO_DEPTH;
        check("ovf_writes", 64'(n_wr), 64'(2));
        check("ovf_flag", 64'(overflow), 64'(1));
        check("ovf_pops", 64'(n_pop), 64'(2));
        check("ovf_byte1", 64'(pop_at(1)), 64'(8'h31));
        check("ovf_done", 64'(n_done), 64'(1));

        // Backpressure with random out_ready.
        reset_obs();
        start_run(2'd0, 16'd8);
        check("bp_overflow_cleared", 64'(overflow), 64'(0));
        step();
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'($urandom % 2);
            drive(1'b0, 1'b1, 8'(8'h80 + i));
        end
        sample_valid = 1'b0;
        wait_idle("bp", 200, 1);
        out_ready = 1'b1;
        report("backpressure");
        check("bp_pop_not_ready", 64'(n_pop_nordy), 64'(0));
        check("bp_pop_empty", 64'(n_pop_empty), 64'(0));
        for (int i = 0; i < 8; i++)
            check($sformatf("bp_byte%0d", i), 64'(pop_at(i)), 64'(8'h80 + i));

        // Abort after 3 of 10 writes; abort wins over the sample on that cycle.
        reset_obs();
        start_run(2'd0, 16'd10);
        step();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h50 + i));
        abort = 1'b1; start = 1'b1;
        drive(1'b0, 1'b1, 8'h53);
        abort = 1'b0; start = 1'b0; sample_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_writes", 64'(n_wr), 64'(3));
        check("abort_clears", 64'(n_clr), 64'(2));
        repeat (3) step();
        check("abort_no_done", 64'(n_done), 64'(0));
        report("abort");

        // Normal run after abort, level trigger.
        reset_obs();
        start_run(2'd3, 16'd2);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h61);
        drive(1'b1, 1'b1, 8'h62);
        sample_valid = 1'b0; trig_in = 1'b0;
        wait_idle("post_abort", 50, 0);
        report("post_abort");
        check("post_abort_done", 64'(n_done), 64'(1));
        check("post_abort_byte0", 64'(pop_at(0)), 64'(8'h61));

        // Randomized sessions, checked cycle by cycle against the model.
        for (int s = 0; s < 25; s++) begin
            logic [1:0]       mode;
            logic [CNT_W-1:0] cnt;
            reset_obs();
            mode = 2'($urandom % 4);
            cnt  = 16'($urandom_range(1, 10));
            if ($urandom % 5 == 0) begin
                cnt = ($urandom % 2 == 0) ? 16'd0 : 16'hFFFF;
                fifo_cap = $urandom_range(2, 6);
            end
            start_run(mode, cnt);
            for (int k = 0; k < 300 && busy; k++) begin
                sample_valid = ($urandom % 4) != 0;
                sample_in    = 8'($urandom);
                if ($urandom % 3 == 0) trig_in = ~trig_in;
                out_ready    = ($urandom % 3) != 0;
                abort        = ($urandom % 80) == 0;
                start        = ($urandom % 40) == 0;
                step();
                abort = 1'b0; start = 1'b0;
            end
            if (busy) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
            end
            sample_valid = 1'b0;
            check($sformatf("rand%0d_idle", s), 64'(busy), 64'(0));
            step();
            fifo_cap = FIFO_DEPTH;
            report($sformatf("session %0d mode %0d count %0d", s, mode, cnt));
        end

        // Asynchronous reset while draining.
        reset_obs(); out_ready = 1'b0; trig_in = 1'b0;
        start_run(2'd0, 16'd5);
        step();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(8'h70 + i));
        sample_valid = 1'b0;
        step();
        check("drain_out_valid", 64'(out_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_all_outputs",
              64'({busy, done, overflow, out_valid, out_data, fifo_en, fifo_rnw, fifo_clear,
                   fifo_data_in}), 64'(0));
        step(); step();
        reset_n = 1'b1;
        step();

        reset_obs(); out_ready = 1'b1;
        start_run(2'd0, 16'd1);
        step();
        drive(1'b0, 1'b1, 8'h9C);
        sample_valid = 1'b0;
        wait_idle("after_reset", 50, 0);
        report("after_reset");
        check("after_reset_byte", 64'(pop_at(0)), 64'(8'h9C));
        check("after_reset_done", 64'(n_done), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
